// File: rtl/apb_fsm_controller.sv
// APB sequencing controller for an AHB-to-APB bridge.
// Drives the APB SETUP/ACCESS phases and stretches the AHB data phase via Hreadyout.
// A wait-state timeout forces completion when a peripheral never raises Pready.
module apb_fsm_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic        Hwrite,
    input  logic [2:0]  tempselx,
    input  logic        Pready,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout,
    output logic        timeout_err
);

    // A zero TIMEOUT still needs a one-bit counter so the vector is legal.
    localparam int unsigned CntW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StWwait,
        StWrite,
        StWenable,
        StRead,
        StRenable
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        sel_q, sel_d;
    logic [31:0]       paddr_d, pwdata_d;
    logic              pwrite_d;
    logic              in_access, timeout_hit, done, accept;

    // Output and completion decode from the registered state.
    always_comb begin
        in_access   = (state_q == StWenable) || (state_q == StRenable);
        timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));
        done        = in_access && (Pready || timeout_hit);
        timeout_err = in_access && !Pready && timeout_hit;
        Penable     = in_access;
        Pselx       = ((state_q == StIdle) || (state_q == StWwait)) ? 3'b000 : sel_q;
        Hreadyout   = (state_q == StIdle) || done;
        accept      = Hreadyout && valid;
    end

    // Next-state, wait counter and APB register loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        sel_d    = sel_q;
        paddr_d  = Paddr;
        pwdata_d = Pwdata;
        pwrite_d = Pwrite;

        unique case (state_q)
            StIdle:  ;
            StWwait: begin
                state_d  = StWrite;
                pwdata_d = Hwdata;
            end
            StWrite: state_d = StWenable;
            StRead:  state_d = StRenable;
            StWenable, StRenable: begin
                if (!done) begin
                    // Saturate so the counter never wraps when the timeout is disabled.
                    cnt_d = (cnt_q != {CntW{1'b1}}) ? cnt_q + CntW'(1) : cnt_q;
                end else if (!valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Accept covers both IDLE and the back-to-back case at ACCESS completion.
        if (accept) begin
            state_d  = Hwrite ? StWwait : StRead;
            paddr_d  = Haddr;
            sel_d    = tempselx;
            pwrite_d = Hwrite;
        end
    end

    // State and APB registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= 3'b000;
            Paddr   <= 32'h0;
            Pwdata  <= 32'h0;
            Pwrite  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            Paddr   <= paddr_d;
            Pwdata  <= pwdata_d;
            Pwrite  <= pwrite_d;
        end
    end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed self-checking bench for apb_fsm_controller.
// Two instances share stimulus: TIMEOUT=15 (main checks) and TIMEOUT=2 (timeout checks).
module tb_apb_fsm_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] Haddr, Hwdata;
    logic        Hwrite;
    logic [2:0]  tempselx;
    logic        Pready;

    logic [2:0]  a_pselx, b_pselx;
    logic        a_penable, b_penable, a_pwrite, b_pwrite;
    logic [31:0] a_paddr, b_paddr, a_pwdata, b_pwdata;
    logic        a_hready, b_hready, a_terr, b_terr;

    int checks = 0;
    int errors = 0;

    apb_fsm_controller #(.TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst), .valid(valid), .Haddr(Haddr), .Hwdata(Hwdata),
        .Hwrite(Hwrite), .tempselx(tempselx), .Pready(Pready),
        .Pselx(a_pselx), .Penable(a_penable), .Pwrite(a_pwrite), .Paddr(a_paddr),
        .Pwdata(a_pwdata), .Hreadyout(a_hready), .timeout_err(a_terr)
    );

    apb_fsm_controller #(.TIMEOUT(2)) dut_b (
        .clk(clk), .rst(rst), .valid(valid), .Haddr(Haddr), .Hwdata(Hwdata),
        .Hwrite(Hwrite), .tempselx(tempselx), .Pready(Pready),
        .Pselx(b_pselx), .Penable(b_penable), .Pwrite(b_pwrite), .Paddr(b_paddr),
        .Pwdata(b_pwdata), .Hreadyout(b_hready), .timeout_err(b_terr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        valid    = 1'b0;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        Hwrite   = 1'b0;
        tempselx = 3'b000;
        Pready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic req(input logic wr, input logic [31:0] addr, input logic [2:0] sel);
        valid    = 1'b1;
        Hwrite   = wr;
        Haddr    = addr;
        tempselx = sel;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pselx", {29'h0, a_pselx}, 32'h0);
        chk("rst_penable", {31'h0, a_penable}, 32'h0);
        chk("rst_pwrite", {31'h0, a_pwrite}, 32'h0);
        chk("rst_paddr", a_paddr, 32'h0);
        chk("rst_pwdata", a_pwdata, 32'h0);
        chk("rst_hready", {31'h0, a_hready}, 32'h1);
        chk("rst_terr", {31'h0, a_terr}, 32'h0);

        // Single read, Pready=1
        req(1'b0, 32'h8000_0010, 3'b001);
        tick();
        valid = 1'b0;
        chk("rd_c1_pselx", {29'h0, a_pselx}, 32'h1);
        chk("rd_c1_penable", {31'h0, a_penable}, 32'h0);
        chk("rd_c1_paddr", a_paddr, 32'h8000_0010);
        chk("rd_c1_hready", {31'h0, a_hready}, 32'h0);
        tick();
        chk("rd_c2_penable", {31'h0, a_penable}, 32'h1);
        chk("rd_c2_hready", {31'h0, a_hready}, 32'h1);
        tick();
        chk("rd_c3_pselx", {29'h0, a_pselx}, 32'h0);
        chk("rd_c3_penable", {31'h0, a_penable}, 32'h0);
        chk("rd_c3_hready", {31'h0, a_hready}, 32'h1);

        // Single write
        req(1'b1, 32'h8400_0004, 3'b010);
        tick();
        valid  = 1'b0;
        Hwdata = 32'hA5A5_5A5A;
        chk("wr_c1_hready", {31'h0, a_hready}, 32'h0);
        chk("wr_c1_pselx", {29'h0, a_pselx}, 32'h0);
        tick();
        Hwdata = 32'h0;
        chk("wr_c2_hready", {31'h0, a_hready}, 32'h0);
        chk("wr_c2_pselx", {29'h0, a_pselx}, 32'h2);
        chk("wr_c2_pwdata", a_pwdata, 32'hA5A5_5A5A);
        chk("wr_c2_pwrite", {31'h0, a_pwrite}, 32'h1);
        chk("wr_c2_paddr", a_paddr, 32'h8400_0004);
        tick();
        chk("wr_c3_hready", {31'h0, a_hready}, 32'h1);
        chk("wr_c3_penable", {31'h0, a_penable}, 32'h1);
        chk("wr_c3_pselx", {29'h0, a_pselx}, 32'h2);
        chk("wr_c3_pwdata", a_pwdata, 32'hA5A5_5A5A);
        tick();
        chk("wr_c4_pselx", {29'h0, a_pselx}, 32'h0);

        // Read with Pready low for 3 ACCESS cycles (TIMEOUT=15)
        do_reset();
        Pready = 1'b0;
        req(1'b0, 32'h8800_0000, 3'b100);
        tick();
        valid = 1'b0;
        chk("rw_setup_pselx", {29'h0, a_pselx}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rw_wait%0d_penable", i), {31'h0, a_penable}, 32'h1);
            chk($sformatf("rw_wait%0d_hready", i), {31'h0, a_hready}, 32'h0);
            chk($sformatf("rw_wait%0d_terr", i), {31'h0, a_terr}, 32'h0);
        end
        tick();
        Pready = 1'b1;
        #1;
        chk("rw_last_penable", {31'h0, a_penable}, 32'h1);
        chk("rw_last_hready", {31'h0, a_hready}, 32'h1);
        chk("rw_last_terr", {31'h0, a_terr}, 32'h0);
        tick();
        chk("rw_idle_penable", {31'h0, a_penable}, 32'h0);

        // Timeout: TIMEOUT=2 instance, Pready held low
        do_reset();
        Pready = 1'b0;
        req(1'b0, 32'h8000_0040, 3'b001);
        tick();
        valid = 1'b0;
        tick();
        chk("to_r1_hready", {31'h0, b_hready}, 32'h0);
        chk("to_r1_terr", {31'h0, b_terr}, 32'h0);
        tick();
        chk("to_r2_hready", {31'h0, b_hready}, 32'h0);
        chk("to_r2_terr", {31'h0, b_terr}, 32'h0);
        tick();
        chk("to_r3_penable", {31'h0, b_penable}, 32'h1);
        chk("to_r3_hready", {31'h0, b_hready}, 32'h1);
        chk("to_r3_terr", {31'h0, b_terr}, 32'h1);
        tick();
        chk("to_idle_penable", {31'h0, b_penable}, 32'h0);
        chk("to_idle_pselx", {29'h0, b_pselx}, 32'h0);
        chk("to_idle_terr", {31'h0, b_terr}, 32'h0);
        chk("to_idle_hready", {31'h0, b_hready}, 32'h1);

        // Back-to-back write then read
        do_reset();
        req(1'b1, 32'h8400_0008, 3'b010);
        tick();
        valid  = 1'b0;
        Hwdata = 32'h1234_5678;
        tick();
        tick();
        req(1'b0, 32'h8000_0020, 3'b001);
        #1;
        chk("b2b_wen_hready", {31'h0, a_hready}, 32'h1);
        chk("b2b_wen_penable", {31'h0, a_penable}, 32'h1);
        chk("b2b_wen_pwdata", a_pwdata, 32'h1234_5678);
        tick();
        valid = 1'b0;
        chk("b2b_rd_penable", {31'h0, a_penable}, 32'h0);
        chk("b2b_rd_pselx", {29'h0, a_pselx}, 32'h1);
        chk("b2b_rd_paddr", a_paddr, 32'h8000_0020);
        chk("b2b_rd_pwrite", {31'h0, a_pwrite}, 32'h0);
        chk("b2b_rd_hready", {31'h0, a_hready}, 32'h0);
        tick();
        chk("b2b_ren_penable", {31'h0, a_penable}, 32'h1);
        chk("b2b_ren_hready", {31'h0, a_hready}, 32'h1);

        // Reset asserted during WENABLE with Pready low
        do_reset();
        Pready = 1'b0;
        req(1'b1, 32'h8400_000C, 3'b010);
        tick();
        valid  = 1'b0;
        Hwdata = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("mr_wen_penable", {31'h0, a_penable}, 32'h1);
        chk("mr_wen_hready", {31'h0, a_hready}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_pselx", {29'h0, a_pselx}, 32'h0);
        chk("mr_penable", {31'h0, a_penable}, 32'h0);
        chk("mr_pwrite", {31'h0, a_pwrite}, 32'h0);
        chk("mr_paddr", a_paddr, 32'h0);
        chk("mr_pwdata", a_pwdata, 32'h0);
        chk("mr_hready", {31'h0, a_hready}, 32'h1);
        chk("mr_terr", {31'h0, a_terr}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mr_post_hready", {31'h0, a_hready}, 32'h1);
        chk("mr_post_pselx", {29'h0, a_pselx}, 32'h0);
        chk("mr_post_penable", {31'h0, a_penable}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_fsm_controller.md
# apb_fsm_controller

Sequencing controller for the AHB-to-APB bridge. It takes the decoded AHB request (`valid`, address, write data, direction, `tempselx`) from the AHB slave interface and drives the APB SETUP/ACCESS phases. It stretches the AHB data phase through `Hreadyout` until the APB slave completes. A wait-state timeout guarantees forward progress when a peripheral never asserts `Pready`.

## Interface
- `TIMEOUT`, default 15: maximum consecutive `Pready`-low ACCESS cycles before forced completion; 0 disables the timeout.
- `clk`  in  1  bridge clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid`  in  1  qualified AHB NONSEQ/SEQ transfer to the bridge range, with `Hreadyin` high.
- `Haddr`  in  32  AHB address-phase address.
- `Hwdata`  in  32  AHB data-phase write data.
- `Hwrite`  in  1  address-phase direction (1 = write).
- `tempselx`  in  3  one-hot peripheral select decoded from `Haddr`.
- `Pready`  in  1  APB slave ready.
- `Pselx`  out  3  APB peripheral selects.
- `Penable`  out  1  APB ACCESS phase.
- `Pwrite`  out  1  APB direction.
- `Paddr`  out  32  APB address.
- `Pwdata`  out  32  APB write data.
- `Hreadyout`  out  1  AHB ready back to the master and to `Hreadyin`.
- `timeout_err`  out  1  one-cycle pulse on forced completion.

## Operation
- States: IDLE, WWAIT, WRITE, WENABLE, READ, RENABLE.
- `Penable`, `Hreadyout`, `timeout_err` and the `Pselx` gating decode from the registered state. `Paddr`, `Pwdata`, `Pwrite` and `sel_q` are registers.
- `Pselx` = `sel_q` in WRITE, WENABLE, READ and RENABLE; `Pselx` = 0 in IDLE and WWAIT.
- `Penable` = 1 only in WENABLE and RENABLE.
- `done` = `Pready` | (`TIMEOUT` != 0 & `cnt` == `TIMEOUT`), evaluated in WENABLE and RENABLE only.
- `Hreadyout` = 1 in IDLE; = `done` in WENABLE and RENABLE; = 0 in WWAIT, WRITE and READ.
- `timeout_err` = ENABLE state & ~`Pready` & `TIMEOUT` != 0 & `cnt` == `TIMEOUT`.
- `cnt` is width max(1, clog2(`TIMEOUT`+1)). It clears to 0 in every non-ENABLE state and on every ENABLE exit. It increments in an ENABLE state while `Pready` = 0 and not `done`. It never wraps.
- Accept event: a state with `Hreadyout` = 1 and `valid` = 1. On accept:
  - `Paddr` <= `Haddr`, `sel_q` <= `tempselx`, `Pwrite` <= `Hwrite`.
  - Next state is WWAIT if `Hwrite`, else READ.
- Transitions:
  - IDLE: accept, otherwise stay.
  - WWAIT -> WRITE unconditionally; `Pwdata` <= `Hwdata` on this edge.
  - WRITE -> WENABLE.
  - READ -> RENABLE.
  - WENABLE / RENABLE: if ~`done`, stay. If `done`, accept (back-to-back, no IDLE cycle) if `valid`, else go to IDLE.
- Registers not being loaded hold their value; `Paddr` and `Pwrite` stay stable through SETUP and ACCESS.
- Read data is not registered here. `Hrdata` = `Prdata` is already on the bus in the cycle where `Hreadyout` = 1.
- Reset, at any point including mid-transfer:
  - state = IDLE, `cnt` = 0.
  - `Pselx` = 0, `Penable` = 0, `Pwrite` = 0, `Paddr` = 0, `Pwdata` = 0, `sel_q` = 0.
  - `Hreadyout` = 1, `timeout_err` = 0.
  - The transfer in flight is abandoned with no completion.
- `tempselx` = 0 with `valid` = 1 cannot occur by construction. If it does, run the full sequence with `Pselx` = 0.

## Timing
- Read, cycle numbering from the accept edge E0, with `Pready` = 1:
  - Cycle 1: READ, `Psel` high, `Hreadyout` 0.
  - Cycle 2: RENABLE, `Penable` high, `Hreadyout` 1.
  - AHB data phase is 2 cycles (1 wait state).
- Write, with `Pready` = 1:
  - Cycle 1: WWAIT, `Hreadyout` 0, `Hwdata` sampled at end.
  - Cycle 2: WRITE.
  - Cycle 3: WENABLE, `Hreadyout` 1.
  - AHB data phase is 3 cycles.
- Each `Pready`-low ACCESS cycle adds one cycle.
- With the timeout enabled, ACCESS lasts at most `TIMEOUT`+1 cycles, and the last one has `Hreadyout` = 1 and `timeout_err` = 1.
- Back-to-back: the edge ending ACCESS with `valid` = 1 is the accept edge of the next transfer. `Pselx` may stay high across the boundary, but `Penable` drops for exactly one cycle (SETUP).

## Test plan
- Reset, then single read of 0x8000_0010, `Pready` = 1:
  - Cycle 1: `Pselx` = 001, `Penable` = 0, `Paddr` = 0x8000_0010.
  - Cycle 2: `Penable` = 1, `Hreadyout` = 1.
  - Cycle 3: IDLE, all APB outputs deasserted.
- Single write to 0x8400_0004 with data 0xA5A5_5A5A:
  - `Hreadyout` 0, 0, 1 over cycles 1-3.
  - `Pselx` = 010 in cycles 2-3.
  - `Pwdata` = 0xA5A5_5A5A and `Pwrite` = 1 from cycle 2.
- Read to 0x8800_0000 with `Pready` low for 3 cycles (`TIMEOUT` = 15): RENABLE held 4 cycles, `Hreadyout` = 1 only in the 4th, `timeout_err` never asserts.
- `TIMEOUT` = 2, `Pready` held 0: RENABLE lasts 3 cycles. The 3rd has `Hreadyout` = 1 and a 1-cycle `timeout_err`, then IDLE.
- Write then read back-to-back with `valid` high at the WENABLE completion edge: next cycle is READ with no IDLE cycle, `Penable` low for exactly 1 cycle, `Paddr` updated.
- Assert `rst` during WENABLE with `Pready` = 0: outputs go to reset values immediately, before the next clock edge. After release, `valid` = 0 keeps the controller in IDLE with `Hreadyout` = 1.
